data_mem_bridge: RTL and testbench

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

---
 rtl/data_mem_bridge_pkg.sv | 13 +
 rtl/data_mem_bridge_bus_timeout_counter.sv | 44 ++++
 rtl/data_mem_bridge.sv | 117 +++++++++++
 tb/tb_data_mem_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_bridge_pkg.sv
// Shared parameters for the data memory bridge.
// State encoding and default bus timeout.
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/data_mem_bridge_bus_timeout_counter.sv
// Wait-cycle counter for the external bus handshake.
// expired_o flags the cycle whose increment would reach LIMIT.
module bus_timeout_counter
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [16:0] LimitW = 17'(LIMIT);

  logic [15:0] count_q;
  logic [15:0] count_d;
  logic [16:0] next_w;

  // Clear has priority so a new transfer always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 16'd1;
    end
  end

  // Widened compare so LIMIT = 65535 cannot wrap.
  assign next_w    = {1'b0, count_q} + 17'd1;
  assign expired_o = enable_i && (next_w == LimitW);

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridge from the data memory controller to the external
// req/ack bus, with timeout abort and registered outputs.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ReadEnable,
  input  logic [3:0]  WriteEnable,
  input  logic [31:0] Address,
  input  logic [31:0] MWriteData,
  output logic        DataMem_Ready,
  output logic [31:0] MReadData,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);

  state_e      state_q;
  logic        ready_q;
  logic        err_q;
  logic        req_q;
  logic [3:0]  we_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic start_w;
  logic wait_w;
  logic expired_w;
  logic unused_addr_lsbs;

  // Byte offset is irrelevant on a word bus.
  assign unused_addr_lsbs = ^Address[1:0];

  // A write request also covers the write-wins-over-read case.
  assign start_w = (state_q == IDLE) && (ReadEnable || (|WriteEnable));
  assign wait_w  = (state_q == BUSY) && !mem_ack;

  bus_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (start_w),
    .enable_i (wait_w),
    .expired_o(expired_w)
  );

  // Transfer FSM; every output comes straight from a register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_w) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            we_q    <= WriteEnable;
            addr_q  <= Address[31:2];
            wdata_q <= MWriteData;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            ready_q <= 1'b1;
            if (we_q == 4'b0000) begin
              rdata_q <= mem_rdata;
            end
          end else if (expired_w) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            if (we_q == 4'b0000) begin
              rdata_q <= 32'h0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign DataMem_Ready = ready_q;
  assign bus_error     = err_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign MReadData     = rdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Testbench for data_mem_bridge: vector table, scoreboard
// of completion results, and a reset-during-transfer case.
module tb_data_mem_bridge;
  import data_mem_bridge_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ReadEnable = 1'b0;
  logic [3:0]  WriteEnable = 4'b0000;
  logic [31:0] Address = '0;
  logic [31:0] MWriteData = '0;
  logic        DataMem_Ready;
  logic [31:0] MReadData;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_error;

  data_mem_bridge #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ReadEnable   (ReadEnable),
    .WriteEnable  (WriteEnable),
    .Address      (Address),
    .MWriteData   (MWriteData),
    .DataMem_Ready(DataMem_Ready),
    .MReadData    (MReadData),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .bus_error    (bus_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        re;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_cyc;
    logic [3:0]  exp_we;
    logic [29:0] exp_addr;
    int          exp_reqs;
    logic        exp_err;
    logic [31:0] exp_mrd;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] mrd;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && DataMem_Ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got 1 required 0 at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_bus_error", 32'(bus_error), 32'(mon_e.err));
        check("sb_MReadData", MReadData, mon_e.mrd);
      end
    end else if (!reset && bus_error) begin
      n_checks++;
      n_fail++;
      $display("FAIL lone_bus_error: got 1 required 0 at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k;
    int  reqs;
    bit  done;

    vecs[0] = '{1'b1, 4'b0000, 32'h1000_0008, 32'h0000_0000,
                32'hDEAD_BEEF, 0, 4'b0000, 30'h0400_0002, 1,
                1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 4'b0011, 32'h2000_0010, 32'h1234_5678,
                32'h0BAD_0BAD, 3, 4'b0011, 30'h0800_0004, 4,
                1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 4'b0000, 32'h3000_0004, 32'h0000_0000,
                32'h7777_7777, -1, 4'b0000, 30'h0C00_0001, 4,
                1'b1, 32'h0000_0000};
    vecs[3] = '{1'b1, 4'b1111, 32'h0000_00FC, 32'hA5A5_A5A5,
                32'h1111_1111, 1, 4'b1111, 30'h0000_003F, 2,
                1'b0, 32'h0000_0000};
    vecs[4] = '{1'b1, 4'b0000, 32'hFFFF_FFFC, 32'h0000_0000,
                32'hCAFE_F00D, 2, 4'b0000, 30'h3FFF_FFFF, 3,
                1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 4'b1000, 32'h0000_0004, 32'h8000_0001,
                32'h2222_2222, 0, 4'b1000, 30'h0000_0001, 1,
                1'b0, 32'hCAFE_F00D};

    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_MReadData", MReadData, 32'd0);
    check("rst_ready", 32'(DataMem_Ready), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      ReadEnable  = vecs[i].re;
      WriteEnable = vecs[i].we;
      Address     = vecs[i].addr;
      MWriteData  = vecs[i].wdata;
      sb_q.push_back('{err: vecs[i].exp_err, mrd: vecs[i].exp_mrd});
      @(posedge clock);
      #1;
      check("req_start", 32'(mem_req), 32'd1);
      reqs = 1;
      k    = 0;
      done = 1'b0;
      while (!done && k < 20) begin
        check("we_hold", 32'(mem_we), 32'(vecs[i].exp_we));
        check("addr_hold", 32'(mem_addr), 32'(vecs[i].exp_addr));
        check("wdata_hold", mem_wdata, vecs[i].wdata);
        check("ready_in_busy", 32'(DataMem_Ready), 32'd0);
        mem_ack   = (vecs[i].wait_cyc == k);
        mem_rdata = mem_ack ? vecs[i].rdata : $urandom;
        @(posedge clock);
        #1;
        mem_ack = 1'b0;
        k++;
        if (mem_req) reqs++;
        else done = 1'b1;
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL req_never_dropped: vector %0d still busy", i);
      end
      check("req_cycles", 32'(reqs), 32'(vecs[i].exp_reqs));
      check("ready_pulse", 32'(DataMem_Ready), 32'd1);
      check("err_with_ready", 32'(bus_error), 32'(vecs[i].exp_err));
      @(posedge clock);
      #1;
      check("ready_one_cycle", 32'(DataMem_Ready), 32'd0);
      check("done_ignores_req", 32'(mem_req), 32'd0);
      ReadEnable  = 1'b0;
      WriteEnable = 4'b0000;
      mem_ack     = 1'b1;
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      check("idle_ack_ready", 32'(DataMem_Ready), 32'd0);
      check("idle_ack_req", 32'(mem_req), 32'd0);
      check("mrd_hold", MReadData, vecs[i].exp_mrd);
    end

    @(negedge clock);
    ReadEnable = 1'b1;
    Address    = 32'h4000_0000;
    @(posedge clock);
    #1;
    check("rb_req_start", 32'(mem_req), 32'd1);
    ReadEnable = 1'b0;
    @(posedge clock);
    #1;
    check("rb_req_busy2", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    check("rb_req_drop", 32'(mem_req), 32'd0);
    check("rb_state_rst", 32'(dut.state_q), 32'(IDLE));
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
    check("rb_late_ack_req", 32'(mem_req), 32'd0);
    check("rb_no_ready", 32'(DataMem_Ready), 32'd0);
    check("rb_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("rb_MReadData", MReadData, 32'd0);

    repeat (2) @(posedge clock);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
